// File: rtl/noc_in_pkg.sv
// rtl/noc_in_pkg.sv - shared types, defaults and width helpers for the NoC input arbiter
//
// Purpose: holds the arbiter FSM state enum, the default parameter values and
// the helpers that size the channel index and the ack timeout counter.
// Ports: none (package).
package noc_in_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_e;

    localparam int DEF_N_REQ          = 4;
    localparam int DEF_DATA_W         = 8;
    localparam int DEF_TIMEOUT_CYCLES = 65535;

    // Index width for n channels; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Timeout counter width, clog2(t+1); a disabled timeout (t == 0) still
    // gets a one-bit counter so no zero-width vector is ever declared.
    function automatic int cnt_w(input int t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin priority picker
//
// Purpose: picks the first requesting channel starting one past last_grant,
// wrapping modulo N_REQ.
// Ports:
//   req        in   N_REQ   request vector
//   last_grant in   IDX_W   channel granted most recently
//   grant      out  N_REQ   one-hot winner (all zero when nothing requests)
//   index      out  IDX_W   winner index (0 when nothing requests)
module rr_arbiter
    import noc_in_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index
);

    logic found;

    always_comb begin : pick
        int cand;
        cand  = 0;
        found = 1'b0;
        grant = '0;
        index = '0;
        // Offsets 1..N_REQ visit every channel once, last_grant itself last.
        for (int off = 1; off <= N_REQ; off++) begin
            cand = int'(last_grant) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/noc_in_arbiter.sv
// rtl/noc_in_arbiter.sv - round-robin NoC channel to PIO word presenter with toggle ack
//
// Purpose: grants one of N_REQ source channels, holds its word on the PIO input
// port until the CPU toggles pio_ack (or the timeout expires), then inserts a
// one-cycle gap before the next grant.
// Ports:
//   clk          in   1             system clock, rising edge
//   reset        in   1             asynchronous active-high reset
//   req_valid    in   N_REQ         per-channel word available
//   req_data     in   N_REQ*DATA_W  channel i at [i*DATA_W +: DATA_W]
//   req_ready    out  N_REQ         one-hot capture strobe, IDLE cycle only
//   pio_data     out  DATA_W        held word (kept after pio_valid falls)
//   pio_valid    out  1             held word valid
//   pio_src      out  IDX_W         channel index of the held word
//   pio_ack      in   1             toggle; each level change consumes a word
//   clr_err      in   1             synchronous clear of err_timeout
//   err_timeout  out  1             sticky: a word was dropped on timeout
module noc_in_arbiter
    import noc_in_pkg::*;
#(
    parameter  int N_REQ          = DEF_N_REQ,
    parameter  int DATA_W         = DEF_DATA_W,
    parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int IDX_W          = idx_w(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       pio_data,
    output logic                    pio_valid,
    output logic [IDX_W-1:0]        pio_src,
    input  logic                    pio_ack,
    input  logic                    clr_err,
    output logic                    err_timeout
);

    localparam int CNT_W = cnt_w(TIMEOUT_CYCLES);
    // Counter value during the last PRESENT cycle before the word is dropped.
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q;
    logic               pio_ack_q;
    logic [IDX_W-1:0]   last_grant_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [DATA_W-1:0]  data_q;
    logic [IDX_W-1:0]   src_q;
    logic               valid_q;
    logic               err_q;

    logic [N_REQ-1:0]   rr_grant;
    logic [IDX_W-1:0]   rr_index;
    logic               ack_edge;
    logic               timeout_hit;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (rr_grant),
        .index      (rr_index)
    );

    assign ack_edge    = pio_ack ^ pio_ack_q;
    assign cnt_d       = cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // The capture strobe must land in the same cycle as the grant decision,
    // so it is the only combinational output; it is masked during reset.
    assign req_ready = ((state_q == IDLE) && !reset) ? rr_grant : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pio_ack_q    <= 1'b0;
            last_grant_q <= IDX_W'(N_REQ - 1);
            cnt_q        <= '0;
            data_q       <= '0;
            src_q        <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            pio_ack_q <= pio_ack;
            // A timeout later in this block overrides the clear.
            if (clr_err) begin
                err_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        data_q       <= req_data[rr_index*DATA_W +: DATA_W];
                        src_q        <= rr_index;
                        last_grant_q <= rr_index;
                        valid_q      <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack_edge) begin
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= GAP;
                    end else if (timeout_hit) begin
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                        state_q <= GAP;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        cnt_q <= cnt_d;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pio_data    = data_q;
    assign pio_src     = src_q;
    assign pio_valid   = valid_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_noc_in_arbiter.sv
// tb/tb_noc_in_arbiter.sv - directed and random self-checking bench for noc_in_arbiter
module tb_noc_in_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   pio_data;
    logic           pio_valid;
    logic [1:0]     pio_src;
    logic           pio_ack;
    logic           clr_err;
    logic           err_timeout;

    int total = 0;
    int bad   = 0;

    noc_in_arbiter #(
        .N_REQ          (N),
        .DATA_W         (W),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .pio_data    (pio_data),
        .pio_valid   (pio_valid),
        .pio_src     (pio_src),
        .pio_ack     (pio_ack),
        .clr_err     (clr_err),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Reference model: "is a word held", "is this the gap cycle", how many
    // cycles the held word has been shown, and who was served last.
    bit m_busy, m_gap, m_err, m_prev_ack;
    int m_last, m_age, m_word, m_src;
    logic [N-1:0] last_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int winner();
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int w;
        r = '0;
        w = winner();
        if (!reset && !m_busy && !m_gap && w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_gap = 0; m_err = 0; m_prev_ack = 0;
        m_last = N - 1; m_age = 0; m_word = 0; m_src = 0;
    endtask

    task automatic model_step();
        bit ack_ev, set_err;
        int w;
        ack_ev     = pio_ack ^ m_prev_ack;
        m_prev_ack = pio_ack;
        set_err    = 0;
        if (m_gap) begin
            m_gap = 0;
        end else if (m_busy) begin
            m_age++;
            if (ack_ev) begin
                m_busy = 0; m_gap = 1;
            end else if (m_age == T) begin
                m_busy = 0; m_gap = 1; set_err = 1;
            end
        end else begin
            w = winner();
            if (w >= 0) begin
                m_busy = 1; m_word = int'(req_data[w*W +: W]);
                m_src = w; m_last = w; m_age = 0;
            end
        end
        if (set_err) m_err = 1;
        else if (clr_err) m_err = 0;
    endtask

    // Called at posedge+1 with inputs already set for this cycle.
    task automatic cyc();
        #1;
        last_ready = req_ready;
        chk("req_ready", req_ready, exp_ready());
        @(posedge clk);
        model_step();
        #1;
        chk("pio_valid", pio_valid, m_busy);
        chk("pio_data", pio_data, m_word);
        chk("pio_src", pio_src, m_src);
        chk("err_timeout", err_timeout, m_err);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_valid", pio_valid, 0);
        chk("rst_data", pio_data, 0);
        chk("rst_src", pio_src, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_err", err_timeout, 0);
        @(posedge clk);
        #1;
        chk("rst_edge_valid", pio_valid, 0);
        chk("rst_edge_data", pio_data, 0);
        reset = 1'b0;
        model_reset();
    endtask

    logic [N-1:0] order [6];
    logic [N-1:0] exp_order [6];
    int n;

    initial begin
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        req_valid = '1;
        req_data  = '0;
        pio_ack   = 1'b0;
        clr_err   = 1'b0;
        model_reset();
        do_reset();
        req_valid = '0;

        // Single word from channel 2.
        req_valid = 4'b0100;
        req_data  = 32'h00A5_0000;
        cyc();
        chk("t1_ready", last_ready, 4'b0100);
        req_valid = '0;
        chk("t1_valid", pio_valid, 1);
        chk("t1_data", pio_data, 8'hA5);
        chk("t1_src", pio_src, 2);
        cyc();
        pio_ack = ~pio_ack;
        cyc();
        chk("t1_drop", pio_valid, 0);
        chk("t1_hold", pio_data, 8'hA5);
        cyc();
        cyc();

        // Fairness: everyone requesting, ack two cycles after each grant.
        do_reset();
        req_valid = '1;
        req_data  = 32'h4433_2211;
        for (int g = 0; g < 6; g++) begin
            cyc();
            order[g] = last_ready;
            cyc();
            pio_ack = ~pio_ack;
            cyc();
            cyc();
        end
        for (int g = 0; g < 6; g++) chk("fair_order", order[g], exp_order[g]);
        req_valid = '0;

        // Timeout, with a clear request landing on the timeout cycle.
        req_valid = 4'b0001;
        req_data  = 32'h0000_0011;
        cyc();
        req_valid = '0;
        n = 0;
        while (pio_valid && n < 40) begin
            if (n == 15) clr_err = 1'b1;
            n++;
            cyc();
            clr_err = 1'b0;
        end
        chk("to_len", n, T);
        chk("to_err", err_timeout, 1);
        cyc();
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        chk("to_clr", err_timeout, 0);

        // Ack arrives in the same cycle the limit is reached.
        req_valid = 4'b0001;
        cyc();
        req_valid = '0;
        repeat (15) cyc();
        chk("col_still", pio_valid, 1);
        pio_ack = ~pio_ack;
        cyc();
        chk("col_valid", pio_valid, 0);
        chk("col_err", err_timeout, 0);
        cyc();

        // Spurious ack while idle must not consume the next word.
        pio_ack = ~pio_ack;
        cyc();
        cyc();
        chk("sp_idle", pio_valid, 0);
        req_valid = 4'b1000;
        req_data  = 32'h7700_0000;
        cyc();
        req_valid = '0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("sp_held", pio_valid, 1);
        end
        chk("sp_data", pio_data, 8'h77);
        pio_ack = ~pio_ack;
        cyc();
        chk("sp_drop", pio_valid, 0);
        cyc();

        // Reset while holding 0x3C from channel 1; channel 0 wins afterwards.
        req_valid = 4'b0010;
        req_data  = 32'h0000_3C00;
        cyc();
        chk("rp_data", pio_data, 8'h3C);
        req_valid = '1;
        do_reset();
        chk("rp_err", err_timeout, 0);
        cyc();
        chk("rp_first", last_ready, 4'b0001);
        req_valid = '0;
        pio_ack = ~pio_ack;
        cyc();
        cyc();
        cyc();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                req_valid = $urandom;
                do_reset();
            end
            req_valid = N'($urandom);
            req_data  = $urandom;
            if ($urandom_range(0, 9) == 0) pio_ack = ~pio_ack;
            clr_err = ($urandom_range(0, 15) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
